// File: rtl/audio_sequencer.sv
`timescale 1ns/1ps
// audio_sequencer: walks a song of two-word events over an iomem-style bus, waits a tick-based
// delay per event, then writes the event data into the audio register bank. Optional: AUDIO_SEQ_LOOP_EN.
module audio_sequencer #(
  parameter int          TICK_DIV   = 16000,
  parameter logic [31:0] AUDIO_BASE = 32'h0300_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] song_base,
  output logic        busy,
  output logic        done,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic [31:0] m_rdata
);

  localparam int DIV_W = $clog2(TICK_DIV);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_A,
    S_FETCH_B,
    S_WAIT,
    S_WRITE
  } state_t;

  state_t           state, state_d;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [31:0]      ptr, ptr_d, base_q, base_d, data_q, data_d;
  logic [15:0]      delay_q, delay_d, cnt_q, cnt_d;
  logic [3:0]       idx_q, idx_d;
  logic             stop_pend, stop_pend_d, busy_d, done_d, m_valid_d;
  logic [31:0]      m_addr_d, m_wdata_d;
  logic [3:0]       m_wstrb_d;
  logic             accept, finish, end_word, loop_word;

  // Free-running tick source; deliberately not re-phased by start.
  assign tick = (div_cnt == DIV_W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!resetn)   div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DIV_W'(1);
  end

  assign accept   = m_valid && m_ready;
  assign end_word = m_rdata[31];
`ifdef AUDIO_SEQ_LOOP_EN
  assign loop_word = m_rdata[30];
`else
  assign loop_word = 1'b0;
`endif

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_d     = state;
    ptr_d       = ptr;
    base_d      = base_q;
    data_d      = data_q;
    delay_d     = delay_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    stop_pend_d = stop_pend;
    busy_d      = busy;
    done_d      = 1'b0;
    m_valid_d   = m_valid;
    m_addr_d    = m_addr;
    m_wdata_d   = m_wdata;
    m_wstrb_d   = m_wstrb;
    finish      = 1'b0;

    if (state == S_IDLE) begin
      if (start && !stop) begin
        ptr_d   = song_base;
        base_d  = song_base;
        busy_d  = 1'b1;
        state_d = S_FETCH_A;
      end
    end else if (m_valid) begin
      // A request in flight is never withdrawn; a stop is remembered until it completes.
      if (!accept) begin
        if (stop) stop_pend_d = 1'b1;
      end else begin
        m_valid_d = 1'b0;
        if (stop || stop_pend) begin
          finish = 1'b1;
        end else begin
          case (state)
            S_FETCH_A: begin
              if (end_word) begin
                if (loop_word) begin
                  ptr_d   = base_q;
                  state_d = S_FETCH_A;
                end else begin
                  finish = 1'b1;
                end
              end else begin
                delay_d = m_rdata[23:8];
                idx_d   = m_rdata[3:0];
                state_d = S_FETCH_B;
              end
            end
            S_FETCH_B: begin
              data_d  = m_rdata;
              cnt_d   = delay_q;
              state_d = S_WAIT;
            end
            S_WRITE: begin
              ptr_d   = ptr + 32'd8;
              state_d = S_FETCH_A;
            end
            default: ;
          endcase
        end
      end
    end else if (stop) begin
      finish = 1'b1;
    end else begin
      // Requests launch only from a cycle with m_valid low, which guarantees the idle gap.
      case (state)
        S_FETCH_A: begin
          m_valid_d = 1'b1;
          m_addr_d  = ptr;
          m_wdata_d = '0;
          m_wstrb_d = 4'b0000;
        end
        S_FETCH_B: begin
          m_valid_d = 1'b1;
          m_addr_d  = ptr + 32'd4;
          m_wdata_d = '0;
          m_wstrb_d = 4'b0000;
        end
        S_WAIT: begin
          if (cnt_q == 16'd0) state_d = S_WRITE;
          else if (tick)      cnt_d   = cnt_q - 16'd1;
        end
        S_WRITE: begin
          m_valid_d = 1'b1;
          m_addr_d  = AUDIO_BASE + {26'd0, idx_q, 2'b00};
          m_wdata_d = data_q;
          m_wstrb_d = 4'b1111;
        end
        default: ;
      endcase
    end

    if (finish) begin
      state_d     = S_IDLE;
      busy_d      = 1'b0;
      done_d      = 1'b1;
      stop_pend_d = 1'b0;
      m_valid_d   = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_IDLE;
      ptr       <= '0;
      base_q    <= '0;
      data_q    <= '0;
      delay_q   <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      stop_pend <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      m_valid   <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      m_wstrb   <= '0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      base_q    <= base_d;
      data_q    <= data_d;
      delay_q   <= delay_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      stop_pend <= stop_pend_d;
      busy      <= busy_d;
      done      <= done_d;
      m_valid   <= m_valid_d;
      m_addr    <= m_addr_d;
      m_wdata   <= m_wdata_d;
      m_wstrb   <= m_wstrb_d;
    end
  end

endmodule

// File: tb/tb_audio_sequencer.sv
`timescale 1ns/1ps
// Scoreboard bench for audio_sequencer: a bus responder serves song words from a small memory
// and checks each completed request against the expected-transaction queue.
module tb_audio_sequencer;

  localparam int          TICK_DIV   = 4;
  localparam logic [31:0] AUDIO_BASE = 32'h0300_0000;

  logic        clk, resetn, start, stop, busy, done, m_valid, m_ready;
  logic [31:0] song_base, m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;

  audio_sequencer #(.TICK_DIV(TICK_DIV), .AUDIO_BASE(AUDIO_BASE)) dut (
    .clk(clk), .resetn(resetn), .start(start), .stop(stop), .song_base(song_base),
    .busy(busy), .done(done), .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } txn_t;

  typedef struct {
    logic [3:0] wstrb;
    int         t_valid;
    int         t_raise;
  } log_t;

  txn_t        exp_q[$];
  log_t        log_q[$];
  logic [31:0] mem [0:255];
  int          vectors, miscompares, cyc, stall, done_cnt, hold_viol, gap_viol, extra_cnt;
  bit          strict = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  // Responder: optional stall, request-hold and idle-gap monitoring, scoreboard compare on completion.
  initial begin : responder
    int   wait_cnt;
    bit   holding;
    int   t_valid;
    txn_t cap;
    txn_t e;
    m_ready  = 1'b0;
    m_rdata  = '0;
    holding  = 1'b0;
    wait_cnt = 0;
    t_valid  = 0;
    forever begin
      @(posedge clk); #1;
      if (m_ready) begin
        m_ready = 1'b0;
        if (m_valid) gap_viol++;
      end else if (!resetn) begin
        if (holding) m_ready = 1'b1;   // late completion arriving while the DUT is in reset
        holding  = 1'b0;
        wait_cnt = 0;
      end else if (m_valid) begin
        if (!holding) begin
          holding  = 1'b1;
          cap      = '{m_addr, m_wdata, m_wstrb};
          t_valid  = cyc;
          wait_cnt = 0;
        end else if (m_addr !== cap.addr || m_wdata !== cap.wdata || m_wstrb !== cap.wstrb) begin
          hold_viol++;
        end
        if (wait_cnt == stall) begin
          m_ready = 1'b1;
          m_rdata = mem[m_addr[9:2]];
          holding = 1'b0;
          log_q.push_back('{m_wstrb, t_valid, cyc});
          if (exp_q.size() == 0) begin
            if (strict) begin
              vectors++;
              miscompares++;
              $display("FAIL unexpected_txn: got addr=%h wstrb=%h wdata=%h, expected none", m_addr, m_wstrb, m_wdata);
            end else begin
              extra_cnt++;
            end
          end else begin
            e = exp_q.pop_front();
            vectors++;
            if (m_addr !== e.addr || m_wstrb !== e.wstrb || (e.wstrb == 4'hF && m_wdata !== e.wdata)) begin
              miscompares++;
              $display("FAIL txn: got addr=%h wstrb=%h wdata=%h, expected addr=%h wstrb=%h wdata=%h",
                       m_addr, m_wstrb, m_wdata, e.addr, e.wstrb, e.wdata);
            end
          end
        end else begin
          wait_cnt++;
        end
      end else if (holding) begin
        hold_viol++;
        holding  = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic load_event(input logic [31:0] a, input logic [31:0] wa, input logic [31:0] wb);
    logic [31:0] a4;
    a4 = a + 32'd4;
    mem[a[9:2]]  = wa;
    mem[a4[9:2]] = wb;
  endtask

  task automatic load_word(input logic [31:0] a, input logic [31:0] w);
    mem[a[9:2]] = w;
  endtask

  task automatic push_rd(input logic [31:0] a);
    exp_q.push_back('{a, 32'h0, 4'h0});
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back('{a, d, 4'hF});
  endtask

  task automatic start_song(input logic [31:0] base);
    @(negedge clk);
    song_base = base;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = (busy === 1'b0);
    @(negedge clk);
  endtask

  task automatic wait_exp(input int remaining, input int budget, output bit ok);
    int n;
    n = 0;
    while (exp_q.size() > remaining && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = (exp_q.size() <= remaining);
  endtask

  task automatic wait_write_valid(input int budget, output bit ok);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(m_valid === 1'b1 && m_wstrb === 4'hF) && n < budget);
    ok = (m_valid === 1'b1 && m_wstrb === 4'hF);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    vectors++;
    if ({busy, done, m_valid, m_wstrb} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got busy=%b done=%b valid=%b wstrb=%h, expected all 0", busy, done, m_valid, m_wstrb);
    end
    vectors++;
    if (m_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_addr: got %h expected 0", m_addr);
    end
    vectors++;
    if (m_wdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_wdata: got %h expected 0", m_wdata);
    end
  endtask

  task automatic test_basic();
    bit ok;
    int d0;
    load_event(32'h40, 32'h0000_0000, 32'h0000_1000);
    load_word(32'h48, 32'h8000_0000);
    push_rd(32'h40); push_rd(32'h44); push_wr(32'h0300_0000, 32'h0000_1000); push_rd(32'h48);
    d0 = done_cnt;
    start_song(32'h40);
    wait_idle(200, ok);
    vectors++;
    if (!ok || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_idle: got busy=%b expected 0", busy);
    end
    vectors++;
    if (done_cnt != d0 + 1) begin
      miscompares++;
      $display("FAIL basic_done: got %0d done pulses expected 1", done_cnt - d0);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL basic_pending: got %0d outstanding expected 0", exp_q.size());
    end
  endtask

  task automatic test_delay();
    bit ok;
    int lat;
    log_q.delete();
    load_event(32'h80, 32'h0000_0305, 32'hABCD_0001);
    load_word(32'h88, 32'h8000_0000);
    push_rd(32'h80); push_rd(32'h84); push_wr(32'h0300_0014, 32'hABCD_0001); push_rd(32'h88);
    start_song(32'h80);
    wait_idle(300, ok);
    lat = (log_q.size() >= 3) ? (log_q[2].t_valid - log_q[1].t_raise) : -1;
    vectors++;
    if (!ok || lat < 12 || lat > 16) begin
      miscompares++;
      $display("FAIL delay_latency: got %0d cycles (idle=%0b) expected 12..16", lat, ok);
    end
  endtask

  task automatic test_stall();
    bit ok;
    int h0;
    h0    = hold_viol;
    stall = 5;
    load_event(32'hC0, 32'h0000_0002, 32'h5555_AAAA);
    load_word(32'hC8, 32'h8000_0000);
    push_rd(32'hC0); push_rd(32'hC4); push_wr(32'h0300_0008, 32'h5555_AAAA); push_rd(32'hC8);
    start_song(32'hC0);
    wait_idle(300, ok);
    stall = 0;
    vectors++;
    if (!ok || hold_viol != h0) begin
      miscompares++;
      $display("FAIL stall_hold: got %0d hold violations (idle=%0b) expected 0", hold_viol - h0, ok);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL stall_pending: got %0d outstanding expected 0", exp_q.size());
    end
  endtask

  task automatic test_stop_wait();
    bit ok;
    log_q.delete();
    load_event(32'h100, 32'h0000_6401, 32'h0000_1234);
    load_word(32'h108, 32'h8000_0000);
    push_rd(32'h100); push_rd(32'h104);
    start_song(32'h100);
    wait_exp(0, 100, ok);
    repeat (5) @(negedge clk);
    pulse_stop();
    vectors++;
    if (!ok || busy !== 1'b0 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL stop_wait: got busy=%b done=%b (fetched=%0b) expected busy=0 done=1", busy, done, ok);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL stop_wait_pulse: got done=%b expected 0", done);
    end
    repeat (20) @(negedge clk);
    vectors++;
    if (log_q.size() != 2) begin
      miscompares++;
      $display("FAIL stop_wait_nowrite: got %0d transactions expected 2", log_q.size());
    end
  endtask

  task automatic test_stop_stall();
    bit ok, ok2;
    int d0;
    log_q.delete();
    d0    = done_cnt;
    stall = 5;
    load_event(32'h140, 32'h0000_0007, 32'hCAFE_F00D);
    load_event(32'h148, 32'h0000_0001, 32'h0000_0001);
    load_word(32'h150, 32'h8000_0000);
    push_rd(32'h140); push_rd(32'h144); push_wr(32'h0300_001C, 32'hCAFE_F00D);
    start_song(32'h140);
    wait_write_valid(200, ok);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_idle(100, ok2);
    repeat (10) @(negedge clk);
    stall = 0;
    vectors++;
    if (!ok || !ok2 || log_q.size() != 3) begin
      miscompares++;
      $display("FAIL stop_stall_txns: got %0d transactions (write=%0b idle=%0b) expected 3", log_q.size(), ok, ok2);
    end
    vectors++;
    if (done_cnt != d0 + 1 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL stop_stall_done: got %0d pulses %0d outstanding expected 1 and 0", done_cnt - d0, exp_q.size());
    end
  endtask

  task automatic test_start_stop_same();
    log_q.delete();
    @(negedge clk);
    song_base = 32'h40;
    start     = 1'b1;
    stop      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL start_stop_same: got busy=%b done=%b expected 0 0", busy, done);
    end
    repeat (10) @(negedge clk);
    vectors++;
    if (log_q.size() != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL start_stop_quiet: got %0d transactions busy=%b expected 0 0", log_q.size(), busy);
    end
  endtask

  task automatic test_start_busy();
    bit ok, ok2;
    int d0;
    d0 = done_cnt;
    load_event(32'h180, 32'h0000_0A04, 32'h0000_0077);
    load_word(32'h188, 32'h8000_0000);
    push_rd(32'h180); push_rd(32'h184); push_wr(32'h0300_0010, 32'h0000_0077); push_rd(32'h188);
    start_song(32'h180);
    wait_exp(2, 100, ok);
    repeat (3) @(negedge clk);
    start_song(32'h40);
    wait_idle(300, ok2);
    vectors++;
    if (!ok || !ok2 || exp_q.size() != 0 || done_cnt != d0 + 1) begin
      miscompares++;
      $display("FAIL start_busy: got %0d outstanding %0d pulses expected 0 and 1", exp_q.size(), done_cnt - d0);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    load_event(32'hFFFF_FFF8, 32'h0000_0009, 32'h0000_0099);
    load_word(32'h0, 32'h8000_0000);
    push_rd(32'hFFFF_FFF8); push_rd(32'hFFFF_FFFC); push_wr(32'h0300_0024, 32'h0000_0099); push_rd(32'h0);
    start_song(32'hFFFF_FFF8);
    wait_idle(200, ok);
    vectors++;
    if (!ok || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL wrap: got %0d outstanding (idle=%0b) expected 0", exp_q.size(), ok);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int highs;
    log_q.delete();
    stall = 3;
    start_song(32'h40);
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      if (m_valid === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    vectors++;
    if (!ok || m_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: got valid=%b busy=%b (seen=%0b) expected 0 0", m_valid, busy, ok);
    end
    highs = 0;
    repeat (10) begin
      @(negedge clk);
      if (m_valid !== 1'b0 || busy !== 1'b0) highs++;
    end
    stall = 0;
    vectors++;
    if (highs != 0 || log_q.size() != 0) begin
      miscompares++;
      $display("FAIL reset_mid_quiet: got %0d active cycles %0d transactions expected 0 0", highs, log_q.size());
    end
  endtask

  task automatic test_loop();
    bit ok, ok2;
    int d0;
    d0 = done_cnt;
    load_event(32'h200, 32'h0000_0003, 32'h0000_00FF);
    load_word(32'h208, 32'hC000_0000);
`ifdef AUDIO_SEQ_LOOP_EN
    repeat (3) begin
      push_rd(32'h200); push_rd(32'h204); push_wr(32'h0300_000C, 32'h0000_00FF); push_rd(32'h208);
    end
    start_song(32'h200);
    wait_exp(0, 400, ok);
    vectors++;
    if (!ok || done_cnt != d0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL loop_running: got %0d pulses busy=%b outstanding=%0d expected 0 1 0", done_cnt - d0, busy, exp_q.size());
    end
    strict = 1'b0;
    pulse_stop();
    wait_idle(100, ok2);
    strict = 1'b1;
    vectors++;
    if (!ok2 || done_cnt != d0 + 1) begin
      miscompares++;
      $display("FAIL loop_stop: got %0d pulses expected 1", done_cnt - d0);
    end
`else
    push_rd(32'h200); push_rd(32'h204); push_wr(32'h0300_000C, 32'h0000_00FF); push_rd(32'h208);
    start_song(32'h200);
    wait_idle(200, ok);
    ok2 = ok;
    vectors++;
    if (!ok2 || exp_q.size() != 0 || done_cnt != d0 + 1) begin
      miscompares++;
      $display("FAIL loop_off: got %0d outstanding %0d pulses expected 0 and 1", exp_q.size(), done_cnt - d0);
    end
`endif
  endtask

  task automatic test_handshake();
    vectors++;
    if (gap_viol != 0) begin
      miscompares++;
      $display("FAIL back_to_back: got %0d gapless requests expected 0", gap_viol);
    end
    vectors++;
    if (hold_viol != 0) begin
      miscompares++;
      $display("FAIL request_hold: got %0d hold violations expected 0", hold_viol);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    start     = 1'b0;
    stop      = 1'b0;
    song_base = '0;
    stall     = 0;
    test_reset();
    test_basic();
    test_delay();
    test_stall();
    test_stop_wait();
    test_stop_stall();
    test_start_stop_same();
    test_start_busy();
    test_wrap();
    test_reset_mid();
    test_loop();
    test_handshake();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
